// File: rtl/game_round_timer.sv
// BCD mm:ss round countdown driven by a prescaler tick, with start/pause/load/clear control and expiry flags.
// Latency: a control or tick_in sampled at edge N updates the digits and flags at edge N; 0 cycles of added delay.
// Backpressure: none; every input is acted on in the cycle it is sampled. Optional blinking low-time warn: GAME_TIMER_WARN_EN.
module game_round_timer #(
  parameter int TICKS_PER_SEC = 1,
  parameter int PRE_MT        = 0,
  parameter int PRE_MO        = 2,
  parameter int PRE_ST        = 0,
  parameter int PRE_SO        = 0,
  parameter int WARN_SEC      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_time,
  input  logic        tick_in,
  input  logic        start,
  input  logic        pause,
  input  logic        load_en,
  input  logic [15:0] load_value,
  output logic [3:0]  min_tens,
  output logic [3:0]  min_ones,
  output logic [3:0]  sec_tens,
  output logic [3:0]  sec_ones,
  output logic        running,
  output logic        expired,
  output logic        expire_pulse,
  output logic        warn
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_PAUSE   = 2'd2;
  localparam logic [1:0] S_EXPIRED = 2'd3;

  localparam logic [7:0] TICK_LAST = 8'(TICKS_PER_SEC - 1);
  localparam logic [3:0] P_MT = 4'(PRE_MT);
  localparam logic [3:0] P_MO = 4'(PRE_MO);
  localparam logic [3:0] P_ST = 4'(PRE_ST);
  localparam logic [3:0] P_SO = 4'(PRE_SO);

  logic [1:0] state;
  logic [7:0] tick_cnt;

  logic [3:0] ld_mt, ld_mo, ld_st, ld_so;
  logic       load_ok, go, hold, is_zero, tick_act, tick_wrap;
  logic [3:0] dec_mt, dec_mo, dec_st, dec_so;
  logic       dec_zero;

  assign ld_mt = load_value[15:12];
  assign ld_mo = load_value[11:8];
  assign ld_st = load_value[7:4];
  assign ld_so = load_value[3:0];

  // A load is refused while running or when any digit is outside its BCD range
  assign load_ok = load_en && (state != S_RUN) &&
                   (ld_mt <= 4'd9) && (ld_mo <= 4'd9) &&
                   (ld_st <= 4'd5) && (ld_so <= 4'd9);

  // start and pause together cancel each other out
  assign go   = start & ~pause;
  assign hold = pause & ~start;

  assign is_zero   = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0000);
  // A pause request in RUN takes precedence over a coincident tick
  assign tick_act  = (state == S_RUN) && !hold && tick_in;
  assign tick_wrap = tick_act && (tick_cnt == TICK_LAST);

  // One-second BCD decrement with borrow ripple; never evaluated at 00:00 in RUN
  always_comb begin
    dec_mt = min_tens;
    dec_mo = min_ones;
    dec_st = sec_tens;
    dec_so = sec_ones;
    if (sec_ones != 4'd0) begin
      dec_so = sec_ones - 4'd1;
    end else begin
      dec_so = 4'd9;
      if (sec_tens != 4'd0) begin
        dec_st = sec_tens - 4'd1;
      end else begin
        dec_st = 4'd5;
        if (min_ones != 4'd0) begin
          dec_mo = min_ones - 4'd1;
        end else begin
          dec_mo = 4'd9;
          dec_mt = min_tens - 4'd1;
        end
      end
    end
  end

  assign dec_zero = ({dec_mt, dec_mo, dec_st, dec_so} == 16'h0000);

  // Control FSM, prescale counter, digits and status flags
  always_ff @(posedge clk) begin
    if (rst || clear_time) begin
      state        <= S_IDLE;
      tick_cnt     <= 8'd0;
      min_tens     <= P_MT;
      min_ones     <= P_MO;
      sec_tens     <= P_ST;
      sec_ones     <= P_SO;
      running      <= 1'b0;
      expired      <= 1'b0;
      expire_pulse <= 1'b0;
    end else if (load_ok) begin
      state        <= S_IDLE;
      tick_cnt     <= 8'd0;
      min_tens     <= ld_mt;
      min_ones     <= ld_mo;
      sec_tens     <= ld_st;
      sec_ones     <= ld_so;
      running      <= 1'b0;
      expired      <= 1'b0;
      expire_pulse <= 1'b0;
    end else begin
      expire_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go && !is_zero) begin
            state    <= S_RUN;
            tick_cnt <= 8'd0;
            running  <= 1'b1;
          end
        end
        S_PAUSE: begin
          if (go) begin
            state   <= S_RUN;
            running <= 1'b1;
          end
        end
        S_RUN: begin
          if (hold) begin
            state   <= S_PAUSE;
            running <= 1'b0;
          end else if (tick_wrap) begin
            tick_cnt <= 8'd0;
            min_tens <= dec_mt;
            min_ones <= dec_mo;
            sec_tens <= dec_st;
            sec_ones <= dec_so;
            if (dec_zero) begin
              state        <= S_EXPIRED;
              running      <= 1'b0;
              expired      <= 1'b1;
              expire_pulse <= 1'b1;
            end
          end else if (tick_act) begin
            tick_cnt <= tick_cnt + 8'd1;
          end
        end
        default: begin
          // EXPIRED waits for reset, clear or a load
        end
      endcase
    end
  end

`ifdef GAME_TIMER_WARN_EN
  localparam logic [12:0] WARN_LIM = 13'(WARN_SEC);

  logic [12:0] cur_secs;
  logic        cur_in_zone, new_in_zone;

  assign cur_secs    = 13'(min_tens) * 13'd600 + 13'(min_ones) * 13'd60 +
                       13'(sec_tens) * 13'd10  + 13'(sec_ones);
  assign cur_in_zone = (cur_secs <= WARN_LIM);
  assign new_in_zone = ((cur_secs - 13'd1) <= WARN_LIM);

  // Warn asserts on entering the low-time zone, then blinks once per decrement while running
  always_ff @(posedge clk) begin
    if (rst || clear_time || load_ok) begin
      warn <= 1'b0;
    end else if (state == S_IDLE) begin
      if (go && !is_zero) warn <= cur_in_zone;
    end else if (tick_wrap) begin
      if (dec_zero)          warn <= 1'b0;
      else if (!new_in_zone) warn <= 1'b0;
      else if (cur_in_zone)  warn <= ~warn;
      else                   warn <= 1'b1;
    end
  end
`else
  assign warn = 1'b0;
`endif

endmodule

// File: doc/game_round_timer.md
Name: game_round_timer

Overview:
- Downstream consumer of the tick prescaler: takes its one-cycle pulse_out as tick_in and runs a BCD mm:ss countdown for a game round.
- Provides start/pause/load/clear control, expiry flag and pulse, and digit outputs for the 7-segment display driver.
- All state is registered; single clock domain.

Parameters:
- TICKS_PER_SEC, 1, tick_in pulses per one-second decrement (1..255).
- PRE_MT, 0, preset minutes-tens BCD digit (0..9).
- PRE_MO, 2, preset minutes-ones BCD digit (0..9).
- PRE_ST, 0, preset seconds-tens BCD digit (0..5).
- PRE_SO, 0, preset seconds-ones BCD digit (0..9).
- WARN_SEC, 10, warning threshold in seconds (binary, 1..59); used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- clear_time  in  1  synchronous clear to preset, active-high.
- tick_in  in  1  one-cycle pulse from the prescaler.
- start  in  1  start/resume request, level sampled each cycle.
- pause  in  1  pause request.
- load_en  in  1  load load_value into the digits.
- load_value  in  16  {mt,mo,st,so}, 4 bits each, BCD.
- min_tens  out  4  BCD digit.
- min_ones  out  4  BCD digit.
- sec_tens  out  4  BCD digit.
- sec_ones  out  4  BCD digit.
- running  out  1  high while in RUN.
- expired  out  1  high while in EXPIRED.
- expire_pulse  out  1  one-cycle pulse on the transition to 00:00.
- warn  out  1  low-time warning (optional feature).

Behaviour:
- Reset (rst=1 at a clk edge):
  - digits = preset; state IDLE; tick counter 0.
  - running=0, expired=0, expire_pulse=0, warn=0.
- Priority each cycle: rst > clear_time > load_en > start/pause > tick_in.
- clear_time: same effect as reset. Legal in any state, including mid-run.
- States:
  - IDLE: start=1, pause=0, digits != 00:00 -> RUN, tick counter cleared. Start with 00:00 is ignored.
  - RUN: pause=1 -> PAUSE, tick counter held. start is ignored.
  - PAUSE: start=1, pause=0 -> RUN, tick counter resumes from its held value.
  - EXPIRED: only rst, clear_time or load_en leave it. start, pause and tick_in are ignored.
- start=1 and pause=1 in the same cycle: no transition in any state.
- load_en is accepted in IDLE, PAUSE or EXPIRED:
  - digits = load_value; state -> IDLE; tick counter cleared.
  - Rejected (no effect) if any digit > 9, sec_tens > 5, or the state is RUN.
- Tick handling in RUN only:
  - On tick_in=1, the counter increments.
  - When counter == TICKS_PER_SEC-1, the counter wraps to 0 and the time decrements by 1 s.
  - tick_in in other states is ignored and does not advance the counter.
- BCD decrement with borrow:
  - so 0 -> 9 and borrow from st; st 0 -> 5 and borrow from mo; mo 0 -> 9 and borrow from mt.
  - Example: 10:00 -> 09:59.
- Expiry: the decrement that produces 00:00 sets the following on the same edge:
  - digits = 00:00, state -> EXPIRED, expired=1, expire_pulse=1 (exactly one cycle), running=0.
- Latency: tick_in sampled at edge N updates the digits and flags at edge N; new values are visible in cycle N+1.
- Digits never leave valid BCD ranges. No decrement below 00:00.
- running and expired are registered and follow the state with zero extra latency.

Optional Feature:
- Macro: GAME_TIMER_WARN_EN.
- Defined:
  - warn=1 while the state is RUN or PAUSE and the remaining time in seconds (mt*600+mo*60+st*10+so) <= WARN_SEC.
  - In RUN, warn toggles on every second decrement (blink); in PAUSE it holds.
  - warn=0 in IDLE and EXPIRED, and on rst or clear_time.
- Undefined: warn is constant 0 and no comparison logic is built. The port remains.

Test Plan:
- Reset with defaults: rst=1 then start=1, TICKS_PER_SEC=1, 120 tick_in pulses -> 02:00, 01:59 ... 00:01, then 00:00 with expired=1, a single-cycle expire_pulse, running=0; a further tick_in leaves 00:00.
- Borrow chain: load 10:00 in IDLE, start, one tick -> 09:59; load 01:00, start, one tick -> 00:59.
- Prescale and pause: TICKS_PER_SEC=3, from 00:05 apply 2 ticks, pause, 5 ticks, start, 1 tick -> 00:04 exactly at the third counted tick; ticks during PAUSE are ignored.
- Control conflicts:
  - start+pause together in RUN -> stays RUN.
  - load_en in RUN -> ignored.
  - load 0x0A00 or 0x0060 -> rejected, digits unchanged.
  - start at 00:00 in IDLE -> stays IDLE.
- Mid-run clear: clear_time at 00:37 in RUN -> next cycle 02:00, IDLE, running=0; clear_time and load_en in the same cycle -> preset wins.
- With GAME_TIMER_WARN_EN, WARN_SEC=10:
  - from 00:12 running -> warn rises at 00:10 and toggles each second.
  - pause at 00:07 -> warn holds.
  - expiry -> warn=0.
